// File: rtl/day_display_scanner_if.sv
// -----------------------------------------------------------------------------
// day_display_scanner_if
//   Bundles the letter inputs, display controls and display outputs of the
//   day-of-week 7-segment scanner into one connection.
//
//   Signals
//     FirstLetter..FourthLetter  4-bit letter codes, leftmost (an[3]) first
//     blank                      1 = all digits dark while scanning continues
//     blink                      1 = flash the display (blink build only)
//     an                         digit enables, active-low
//     seg                        segments {g,f,e,d,c,b,a}, active-low
//     frame_done                 1-cycle pulse when the shadow letters load
//
//   Modports
//     master  letter source / display consumer side
//     slave   scanner side
// -----------------------------------------------------------------------------
interface day_display_scanner_if;
  logic [3:0] FirstLetter;
  logic [3:0] SecondLetter;
  logic [3:0] ThirdLetter;
  logic [3:0] FourthLetter;
  logic       blank;
  logic       blink;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  modport master (
    output FirstLetter, SecondLetter, ThirdLetter, FourthLetter,
    output blank, blink,
    input  an, seg, frame_done
  );

  modport slave (
    input  FirstLetter, SecondLetter, ThirdLetter, FourthLetter,
    input  blank, blink,
    output an, seg, frame_done
  );
endinterface

// File: rtl/day_display_scanner.sv
// -----------------------------------------------------------------------------
// day_display_scanner
//   Time-multiplexes four letter codes onto a 4-digit common-anode 7-segment
//   display. The letters are double-buffered: a shadow copy is loaded only on
//   the last cycle of a frame (idx==3 wrap), so a change in the middle of a
//   frame never produces a torn display.
//
//   Ports
//     clk        system clock, every register on its rising edge
//     resetTime  synchronous, active-high reset (wins over all other inputs)
//     bus        day_display_scanner_if.slave (letters, blank, blink, an,
//                seg, frame_done)
//
//   Parameters
//     SCAN_DIV      clock cycles each digit stays enabled (>= 2)
//     BLINK_FRAMES  frames per blink half-period (blink build only)
//
//   Build option
//     DISP_BLINK_EN  when defined, blink=1 alternates BLINK_FRAMES frames of
//                    normal display with BLINK_FRAMES frames of darkness.
//                    When undefined the blink input is ignored.
// -----------------------------------------------------------------------------

// Sanity checks on the scanner outputs; kept apart from the datapath.
module day_display_scanner_checker (
  input logic       clk,
  input logic       resetTime,
  input logic [3:0] an,
  input logic [6:0] seg,
  input logic       frame_done
);
  // At most one digit is ever enabled.
  a_an_one_digit: assert property (@(posedge clk)
    !resetTime |-> (an == 4'b1111 || $onehot(~an)));

  // A dark display has every segment off.
  a_dark_is_blank: assert property (@(posedge clk)
    (an == 4'b1111) |-> (seg == 7'h7F));

  // The capture pulse is a single cycle wide.
  a_frame_done_pulse: assert property (@(posedge clk)
    frame_done |=> !frame_done);
endmodule

module day_display_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input logic                  clk,
  input logic                  resetTime,
  day_display_scanner_if.slave bus
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Active-high glyph for each letter code; unused codes stay dark.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'd0:    glyph = 7'h00;  // space
      4'd1:    glyph = 7'h77;  // A
      4'd2:    glyph = 7'h5E;  // d
      4'd3:    glyph = 7'h79;  // E
      4'd4:    glyph = 7'h71;  // F
      4'd5:    glyph = 7'h76;  // H
      4'd6:    glyph = 7'h30;  // I
      4'd7:    glyph = 7'h54;  // n
      4'd8:    glyph = 7'h5C;  // o
      4'd9:    glyph = 7'h73;  // P
      4'd10:   glyph = 7'h50;  // r
      4'd11:   glyph = 7'h6D;  // S
      4'd12:   glyph = 7'h78;  // t
      4'd13:   glyph = 7'h3E;  // U
      default: glyph = 7'h00;  // 14, 15: dark
    endcase
  endfunction

  logic [DIV_W-1:0] divcnt_r;
  logic [1:0]       idx_r;
  logic [3:0]       shadow_r [4];
  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic             frame_done_r;

  logic             wrap_s;
  logic             frame_edge_s;
  logic [3:0]       code_s;
  logic [3:0]       an_next_s;
  logic             dark_s;

  // Digit wrap and frame boundary decode.
  always_comb begin
    wrap_s       = (divcnt_r == DIV_LAST);
    frame_edge_s = wrap_s && (idx_r == 2'd3);
  end

  // Select the shadow letter of the digit currently being scanned.
  always_comb begin
    code_s    = 4'd0;
    an_next_s = ~(4'b1000 >> idx_r);
    case (idx_r)
      2'd0:    code_s = shadow_r[0];
      2'd1:    code_s = shadow_r[1];
      2'd2:    code_s = shadow_r[2];
      2'd3:    code_s = shadow_r[3];
      default: code_s = 4'd0;
    endcase
  end

`ifdef DISP_BLINK_EN
  localparam int               BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [BLK_W-1:0] blink_cnt_r;
  logic             phase_r;

  // Frame counter for the blink half-period; phase 1 means "dark half".
  // Dropping blink restarts the pattern from a visible half.
  always_ff @(posedge clk) begin
    if (resetTime) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (!bus.blink) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (frame_edge_s) begin
      if (blink_cnt_r == BLK_LAST) begin
        blink_cnt_r <= '0;
        phase_r     <= ~phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLK_W'(1);
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
      phase_r     <= phase_r;
    end
  end

  // Darkness request: explicit blank, or the dark half of a blink.
  always_comb begin
    dark_s = bus.blank || (bus.blink && phase_r);
  end
`else
  logic unused_blink_s;

  // Blink has no effect in this build.
  always_comb begin
    unused_blink_s = bus.blink;
    dark_s         = bus.blank;
  end
`endif

  // Scan divider, digit ring, shadow capture and registered display outputs.
  // The outputs are computed from the pre-edge idx, hence one cycle of lag.
  always_ff @(posedge clk) begin
    if (resetTime) begin
      divcnt_r     <= '0;
      idx_r        <= 2'd0;
      shadow_r[0]  <= 4'd0;
      shadow_r[1]  <= 4'd0;
      shadow_r[2]  <= 4'd0;
      shadow_r[3]  <= 4'd0;
      an_r         <= 4'b1111;
      seg_r        <= 7'h7F;
      frame_done_r <= 1'b0;
    end else begin
      if (wrap_s) begin
        divcnt_r <= '0;
        idx_r    <= idx_r + 2'd1;
      end else begin
        divcnt_r <= divcnt_r + DIV_W'(1);
        idx_r    <= idx_r;
      end

      // Letters are sampled only here, at the end of the last digit.
      if (frame_edge_s) begin
        shadow_r[0] <= bus.FirstLetter;
        shadow_r[1] <= bus.SecondLetter;
        shadow_r[2] <= bus.ThirdLetter;
        shadow_r[3] <= bus.FourthLetter;
      end else begin
        shadow_r[0] <= shadow_r[0];
        shadow_r[1] <= shadow_r[1];
        shadow_r[2] <= shadow_r[2];
        shadow_r[3] <= shadow_r[3];
      end
      frame_done_r <= frame_edge_s;

      if (dark_s) begin
        an_r  <= 4'b1111;
        seg_r <= 7'h7F;
      end else begin
        an_r  <= an_next_s;
        seg_r <= ~glyph(code_s);
      end
    end
  end

  assign bus.an         = an_r;
  assign bus.seg        = seg_r;
  assign bus.frame_done = frame_done_r;

  day_display_scanner_checker u_checker (
    .clk        (clk),
    .resetTime  (resetTime),
    .an         (an_r),
    .seg        (seg_r),
    .frame_done (frame_done_r)
  );

endmodule

// File: tb/tb_day_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_day_display_scanner
//   Directed bench for day_display_scanner with SCAN_DIV=4, BLINK_FRAMES=2.
//   With SCAN_DIV=4 a frame is 16 clock edges after a frame start; digit k
//   (0 = leftmost) is shown on edges 4k+1..4k+4 and frame_done is high after
//   edge 16. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_day_display_scanner;

`ifdef DISP_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic clk;
  logic resetTime;
  int   checks;
  int   fails;

  day_display_scanner_if bus ();

  day_display_scanner #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk       (clk),
    .resetTime (resetTime),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] digit_an(input int k);
    logic [3:0] msb;
    msb = 4'b1000;
    return ~(msb >> k);
  endfunction

  task automatic set_letters(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
    bus.FirstLetter  = a;
    bus.SecondLetter = b;
    bus.ThirdLetter  = c;
    bus.FourthLetter = d;
  endtask

  task automatic test_reset();
    set_letters(4'd12, 4'd13, 4'd3, 4'd0);
    bus.blank = 1'b0;
    bus.blink = 1'b0;
    resetTime = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.an !== 4'b1111 || bus.seg !== 7'h7F || bus.frame_done !== 1'b0) begin
        fails++;
        $display("FAIL reset_state cyc%0d: an=%b seg=%h fd=%b, want an=1111 seg=7f fd=0",
                 i, bus.an, bus.seg, bus.frame_done);
      end
    end
    resetTime = 1'b0;
  endtask

  task automatic test_first_frame();
    for (int s = 1; s <= 16; s++) begin
      step();
      checks++;
      if (bus.an !== digit_an((s - 1) / 4) || bus.seg !== 7'h7F ||
          bus.frame_done !== (s == 16)) begin
        fails++;
        $display("FAIL first_frame s%0d: an=%b seg=%h fd=%b, want an=%b seg=7f fd=%0d",
                 s, bus.an, bus.seg, bus.frame_done, digit_an((s - 1) / 4), (s == 16));
      end
    end
  endtask

  task automatic test_letters();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h07, 7'h41, 7'h06, 7'h7F};
    for (int s = 1; s <= 16; s++) begin
      step();
      checks++;
      if (bus.an !== digit_an((s - 1) / 4) || bus.seg !== exp_seg[(s - 1) / 4] ||
          bus.frame_done !== (s == 16)) begin
        fails++;
        $display("FAIL letters s%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%0d",
                 s, bus.an, bus.seg, bus.frame_done, digit_an((s - 1) / 4),
                 exp_seg[(s - 1) / 4], (s == 16));
      end
    end
  endtask

  task automatic test_mid_frame_change();
    logic [6:0] old_seg [4];
    logic [6:0] new_seg [4];
    logic [6:0] want;
    old_seg = '{7'h07, 7'h41, 7'h06, 7'h7F};
    new_seg = '{7'h2B, 7'h2B, 7'h23, 7'h2B};
    for (int f = 0; f < 2; f++) begin
      for (int s = 1; s <= 16; s++) begin
        step();
        want = (f == 0) ? old_seg[(s - 1) / 4] : new_seg[(s - 1) / 4];
        checks++;
        if (bus.an !== digit_an((s - 1) / 4) || bus.seg !== want ||
            bus.frame_done !== (s == 16)) begin
          fails++;
          $display("FAIL mid_frame_change f%0d s%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%0d",
                   f, s, bus.an, bus.seg, bus.frame_done, digit_an((s - 1) / 4), want, (s == 16));
        end
        if (f == 0 && s == 6) set_letters(4'd7, 4'd7, 4'd8, 4'd7);
      end
    end
  endtask

  task automatic test_unused_codes();
    logic [6:0] old_seg [4];
    logic [6:0] new_seg [4];
    logic [6:0] want;
    old_seg = '{7'h2B, 7'h2B, 7'h23, 7'h2B};
    new_seg = '{7'h7F, 7'h09, 7'h7F, 7'h4F};
    set_letters(4'd14, 4'd5, 4'd15, 4'd6);
    for (int f = 0; f < 2; f++) begin
      for (int s = 1; s <= 16; s++) begin
        step();
        want = (f == 0) ? old_seg[(s - 1) / 4] : new_seg[(s - 1) / 4];
        checks++;
        if (bus.an !== digit_an((s - 1) / 4) || bus.seg !== want) begin
          fails++;
          $display("FAIL unused_codes f%0d s%0d: an=%b seg=%h, want an=%b seg=%h",
                   f, s, bus.an, bus.seg, digit_an((s - 1) / 4), want);
        end
      end
    end
  endtask

  task automatic test_blank();
    logic [6:0] exp_seg [4];
    logic [3:0] want_an;
    logic [6:0] want_seg;
    bit         dark;
    exp_seg = '{7'h7F, 7'h09, 7'h7F, 7'h4F};
    for (int s = 1; s <= 16; s++) begin
      step();
      dark     = (s >= 3 && s <= 8);
      want_an  = dark ? 4'b1111 : digit_an((s - 1) / 4);
      want_seg = dark ? 7'h7F : exp_seg[(s - 1) / 4];
      checks++;
      if (bus.an !== want_an || bus.seg !== want_seg || bus.frame_done !== (s == 16)) begin
        fails++;
        $display("FAIL blank s%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%0d",
                 s, bus.an, bus.seg, bus.frame_done, want_an, want_seg, (s == 16));
      end
      if (s == 2) bus.blank = 1'b1;
      if (s == 8) bus.blank = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int s = 1; s <= 15; s++) step();
    resetTime = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.an !== 4'b1111 || bus.seg !== 7'h7F || bus.frame_done !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_frame cyc%0d: an=%b seg=%h fd=%b, want an=1111 seg=7f fd=0",
                 i, bus.an, bus.seg, bus.frame_done);
      end
    end
    resetTime = 1'b0;
    for (int s = 1; s <= 16; s++) begin
      step();
      checks++;
      if (bus.an !== digit_an((s - 1) / 4) || bus.seg !== 7'h7F ||
          bus.frame_done !== (s == 16)) begin
        fails++;
        $display("FAIL after_reset s%0d: an=%b seg=%h fd=%b, want an=%b seg=7f fd=%0d",
                 s, bus.an, bus.seg, bus.frame_done, digit_an((s - 1) / 4), (s == 16));
      end
    end
  endtask

  task automatic test_blink();
    logic [6:0] exp_seg [4];
    logic [3:0] want_an;
    logic [6:0] want_seg;
    bit         dark;
    exp_seg   = '{7'h7F, 7'h09, 7'h7F, 7'h4F};
    bus.blink = 1'b1;
    for (int f = 1; f <= 8; f++) begin
      for (int s = 1; s <= 16; s++) begin
        step();
        dark     = BLINK_ON && (f == 3 || f == 4 || (f == 7 && s <= 3));
        want_an  = dark ? 4'b1111 : digit_an((s - 1) / 4);
        want_seg = dark ? 7'h7F : exp_seg[(s - 1) / 4];
        checks++;
        if (bus.an !== want_an || bus.seg !== want_seg || bus.frame_done !== (s == 16)) begin
          fails++;
          $display("FAIL blink f%0d s%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%0d",
                   f, s, bus.an, bus.seg, bus.frame_done, want_an, want_seg, (s == 16));
        end
        if (f == 7 && s == 3) bus.blink = 1'b0;
      end
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    resetTime = 1'b1;
    bus.blank = 1'b0;
    bus.blink = 1'b0;
    set_letters(4'd0, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_first_frame();
    test_letters();
    test_mid_frame_change();
    test_unused_codes();
    test_blank();
    test_reset_mid_frame();
    test_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
